local_bus_reg_bank: RTL and testbench



---
 rtl/local_bus_reg_bank.sv | 128 ++++++++++++
 tb/tb_local_bus_reg_bank.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/local_bus_reg_bank.sv
// Local Bus register bank: version, W1C status, control/IRQ mask, write counter, general RW regs.
// Reads return RD_LATENCY cycles after CS with a one-cycle DV; writes land at the CS edge; no backpressure.
module local_bus_reg_bank #(
  parameter int          ADDR8_PER_CS = 65536,
  parameter int          NUM_RW_REGS  = 8,
  parameter int          RD_LATENCY   = 1,
  parameter logic [15:0] VERSION      = 16'h0101,
  localparam int         AW           = $clog2(ADDR8_PER_CS)
) (
  input  logic                      i_Bus_Clk,
  input  logic                      i_Rst_L,
  input  logic                      i_Bus_CS,
  input  logic                      i_Bus_Wr_Rd_n,
  input  logic [AW-1:0]             i_Bus_Addr8,
  input  logic [15:0]               i_Bus_Wr_Data,
  output logic [15:0]               o_Bus_Rd_Data,
  output logic                      o_Bus_Rd_DV,
  input  logic [7:0]                i_Event,
  output logic [15:0]               o_Ctrl,
  output logic [NUM_RW_REGS*16-1:0] o_Regs,
  output logic                      o_Irq
);

  logic [AW-1:0]          word_addr;
  logic                   wr_stb, rd_stb;
  logic                   hit_ver, hit_status, hit_ctrl, hit_cnt;
  logic [NUM_RW_REGS-1:0] hit_reg;
  logic                   wr_counted;
  logic [15:0]            rd_word;

  logic [7:0]  status_q, status_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [15:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;
  logic [15:0] regs_q [NUM_RW_REGS];
  logic [15:0] regs_d [NUM_RW_REGS];

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [15:0]           dat_q [RD_LATENCY];
  logic [15:0]           dat_d [RD_LATENCY];

  // Byte address bit 0 selects nothing: the bank is 16-bit word addressed.
  assign word_addr  = i_Bus_Addr8 & ~AW'(1);
  assign wr_stb     = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign rd_stb     = i_Bus_CS & ~i_Bus_Wr_Rd_n;
  assign hit_ver    = (word_addr == AW'(0));
  assign hit_status = (word_addr == AW'(2));
  assign hit_ctrl   = (word_addr == AW'(4));
  assign hit_cnt    = (word_addr == AW'(6));

  always_comb begin
    hit_reg = '0;
    for (int n = 0; n < NUM_RW_REGS; n++) begin
      hit_reg[n] = (word_addr == AW'(16 + 2 * n));
    end
  end

  assign wr_counted = wr_stb & (hit_status | hit_ctrl | (|hit_reg));

  always_comb begin
    rd_word = '0;
    if (hit_ver)    rd_word = VERSION;
    if (hit_status) rd_word = {8'h00, status_q};
    if (hit_ctrl)   rd_word = ctrl_q;
    if (hit_cnt)    rd_word = cnt_q;
    for (int n = 0; n < NUM_RW_REGS; n++) begin
      if (hit_reg[n]) rd_word = regs_q[n];
    end
  end

  always_comb begin
    // Event set is OR-ed after the clear so a coincident event survives the W1C.
    status_d = (status_q & ~((wr_stb & hit_status) ? i_Bus_Wr_Data[7:0] : 8'h00)) | i_Event;
    ctrl_d   = (wr_stb & hit_ctrl) ? i_Bus_Wr_Data : ctrl_q;
    cnt_d    = cnt_q;
    if (wr_stb & hit_cnt) begin
      cnt_d = '0;
    end else if (wr_counted) begin
      cnt_d = cnt_q + 16'd1;
    end
    for (int n = 0; n < NUM_RW_REGS; n++) begin
      regs_d[n] = (wr_stb & hit_reg[n]) ? i_Bus_Wr_Data : regs_q[n];
    end
    irq_d = |(status_q & ctrl_q[15:8]);
  end

  // Each stage only loads when a read enters it, so the last stage holds its data between pulses.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_stb;
    dat_d    = dat_q;
    if (rd_stb) dat_d[0] = rd_word;
    for (int k = 1; k < RD_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) dat_d[k] = dat_q[k-1];
    end
  end

  always_ff @(posedge i_Bus_Clk) begin
    if (!i_Rst_L) begin
      status_q <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
      vld_q    <= '0;
      for (int n = 0; n < NUM_RW_REGS; n++) regs_q[n] <= '0;
      for (int k = 0; k < RD_LATENCY; k++) dat_q[k] <= '0;
    end else begin
      status_q <= status_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
      vld_q    <= vld_d;
      for (int n = 0; n < NUM_RW_REGS; n++) regs_q[n] <= regs_d[n];
      for (int k = 0; k < RD_LATENCY; k++) dat_q[k] <= dat_d[k];
    end
  end

  assign o_Bus_Rd_DV   = vld_q[RD_LATENCY-1];
  assign o_Bus_Rd_Data = dat_q[RD_LATENCY-1];
  assign o_Ctrl        = ctrl_q;
  assign o_Irq         = irq_q;

  for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_regs_out
    assign o_Regs[16*g +: 16] = regs_q[g];
  end

endmodule

// File: tb/tb_local_bus_reg_bank.sv
// Drives two banks (read latency 1 and 2) with identical traffic and scoreboards both against
// a register-map model; monitors pop expected read data whenever a DV appears.
module tb_local_bus_reg_bank;
  localparam int NREG = 8;

  typedef struct {
    logic [15:0] dat;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b0;
  logic wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdat = '0;
  logic [7:0]  ev = '0;

  logic [15:0]        rd_dat1, rd_dat2, ctrl1, ctrl2;
  logic               dv1, dv2, irq1, irq2;
  logic [NREG*16-1:0] regs1, regs2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_edge = 1'b0;
  exp_t q1[$];
  exp_t q2[$];
  logic [15:0] last1 = '0;
  logic [15:0] last2 = '0;

  // Reference model of the register map
  logic [7:0]  m_status = '0;
  logic [15:0] m_ctrl = '0;
  logic [15:0] m_cnt = '0;
  logic        m_irq = 1'b0;
  logic [15:0] m_regs [NREG];

  local_bus_reg_bank #(.RD_LATENCY(1)) dut1 (
    .i_Bus_Clk(clk), .i_Rst_L(rst_n), .i_Bus_CS(cs), .i_Bus_Wr_Rd_n(wr),
    .i_Bus_Addr8(addr), .i_Bus_Wr_Data(wdat), .o_Bus_Rd_Data(rd_dat1),
    .o_Bus_Rd_DV(dv1), .i_Event(ev), .o_Ctrl(ctrl1), .o_Regs(regs1), .o_Irq(irq1)
  );

  local_bus_reg_bank #(.RD_LATENCY(2)) dut2 (
    .i_Bus_Clk(clk), .i_Rst_L(rst_n), .i_Bus_CS(cs), .i_Bus_Wr_Rd_n(wr),
    .i_Bus_Addr8(addr), .i_Bus_Wr_Data(wdat), .o_Bus_Rd_Data(rd_dat2),
    .o_Bus_Rd_DV(dv2), .i_Event(ev), .o_Ctrl(ctrl2), .o_Regs(regs2), .o_Irq(irq2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    int w = int'(a & 16'hFFFE);
    if (w == 0) return 16'h0101;
    if (w == 2) return {8'h00, m_status};
    if (w == 4) return m_ctrl;
    if (w == 6) return m_cnt;
    if (w >= 16 && w < 16 + 2 * NREG) return m_regs[(w - 16) / 2];
    return 16'h0000;
  endfunction

  function automatic logic [NREG*16-1:0] model_regs();
    logic [NREG*16-1:0] v;
    for (int n = 0; n < NREG; n++) v[16*n +: 16] = m_regs[n];
    return v;
  endfunction

  // One bus cycle: check registered outputs, drive inputs, advance the model across the edge.
  task automatic step(input logic c, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [7:0] e);
    int wa;
    logic [7:0] clr;
    @(negedge clk);
    chk("ctrl1", ctrl1, m_ctrl);
    chk("ctrl2", ctrl2, m_ctrl);
    chk("regs1", regs1, model_regs());
    chk("regs2", regs2, model_regs());
    chk("irq1", irq1, m_irq);
    chk("irq2", irq2, m_irq);
    cs = c; wr = w; addr = a; wdat = d; ev = e;
    if (c && !w) begin
      q1.push_back('{model_read(a), cyc + 1});
      q2.push_back('{model_read(a), cyc + 2});
    end
    m_irq = |(m_status & m_ctrl[15:8]);
    wa = int'(a & 16'hFFFE);
    clr = 8'h00;
    if (c && w) begin
      if (wa == 2) begin
        clr = d[7:0];
        m_cnt = m_cnt + 16'd1;
      end else if (wa == 4) begin
        m_ctrl = d;
        m_cnt = m_cnt + 16'd1;
      end else if (wa == 6) begin
        m_cnt = 16'h0000;
      end else if (wa >= 16 && wa < 16 + 2 * NREG) begin
        m_regs[(wa - 16) / 2] = d;
        m_cnt = m_cnt + 16'd1;
      end
    end
    m_status = (m_status & ~clr) | e;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0, 16'h0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; ev = 8'h00;
    // Reads whose DV would land on or after the reset edge are lost.
    while (q1.size() > 0 && q1[q1.size()-1].due > cyc) q1.delete(q1.size() - 1);
    while (q2.size() > 0 && q2[q2.size()-1].due > cyc) q2.delete(q2.size() - 1);
    m_status = '0; m_ctrl = '0; m_cnt = '0; m_irq = 1'b0;
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_edge) begin
      chk("dv1_rst", dv1, 1'b0);
      chk("dat1_rst", rd_dat1, 16'h0);
      last1 = 16'h0;
    end else if (dv1) begin
      if (q1.size() == 0) begin
        chk("dv1_unexpected", dv1, 1'b0);
      end else begin
        e = q1.pop_front();
        chk("dv1_cycle", cyc, e.due);
        chk("dat1", rd_dat1, e.dat);
        last1 = e.dat;
      end
    end else begin
      chk("dat1_hold", rd_dat1, last1);
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        chk("dv1_missing", dv1, 1'b1);
        q1.delete(0);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_edge) begin
      chk("dv2_rst", dv2, 1'b0);
      chk("dat2_rst", rd_dat2, 16'h0);
      last2 = 16'h0;
    end else if (dv2) begin
      if (q2.size() == 0) begin
        chk("dv2_unexpected", dv2, 1'b0);
      end else begin
        e = q2.pop_front();
        chk("dv2_cycle", cyc, e.due);
        chk("dat2", rd_dat2, e.dat);
        last2 = e.dat;
      end
    end else begin
      chk("dat2_hold", rd_dat2, last2);
      if (q2.size() > 0 && q2[0].due <= cyc) begin
        chk("dv2_missing", dv2, 1'b1);
        q2.delete(0);
      end
    end
  end

  initial begin
    logic [15:0] ra;
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    do_reset(3);

    // Version and control after reset
    step(1'b1, 1'b0, 16'h0000, 16'h0, 8'h00);
    step(1'b1, 1'b0, 16'h0004, 16'h0, 8'h00);
    idle(3);

    // General register via odd byte address, then counter
    step(1'b1, 1'b1, 16'h0012, 16'hA5C3, 8'h00);
    step(1'b1, 1'b0, 16'h0013, 16'h0, 8'h00);
    step(1'b1, 1'b0, 16'h0006, 16'h0, 8'h00);
    idle(2);

    // Sticky status, IRQ mask, W1C and set-wins-over-clear
    step(1'b0, 1'b0, 16'h0, 16'h0, 8'h08);
    step(1'b1, 1'b1, 16'h0004, 16'h0800, 8'h00);
    step(1'b1, 1'b0, 16'h0002, 16'h0, 8'h00);
    idle(2);
    step(1'b1, 1'b1, 16'h0002, 16'h0008, 8'h00);
    idle(2);
    step(1'b1, 1'b1, 16'h0002, 16'h0008, 8'h08);
    step(1'b1, 1'b0, 16'h0002, 16'h0, 8'h08);
    idle(3);

    // Unmapped address, VERSION write ignored
    step(1'b1, 1'b0, 16'h0100, 16'h0, 8'h00);
    step(1'b1, 1'b1, 16'h0100, 16'hDEAD, 8'h00);
    step(1'b1, 1'b1, 16'h0000, 16'hBEEF, 8'h00);
    step(1'b1, 1'b0, 16'h0006, 16'h0, 8'h00);
    step(1'b1, 1'b0, 16'h0000, 16'h0, 8'h00);
    idle(2);

    // Back-to-back reads, then reset one cycle after a read
    step(1'b1, 1'b0, 16'h0000, 16'h0, 8'h00);
    step(1'b1, 1'b0, 16'h0010, 16'h0, 8'h00);
    step(1'b1, 1'b0, 16'h0000, 16'h0, 8'h00);
    do_reset(2);
    idle(2);

    // Counter wrap and clear-by-write
    step(1'b1, 1'b1, 16'h0006, 16'h0, 8'h00);
    repeat (65535) step(1'b1, 1'b1, 16'h0010, 16'($urandom), 8'h00);
    step(1'b1, 1'b0, 16'h0006, 16'h0, 8'h00);
    step(1'b1, 1'b1, 16'h0014, 16'h1111, 8'h00);
    step(1'b1, 1'b0, 16'h0006, 16'h0, 8'h00);
    step(1'b1, 1'b1, 16'h0006, 16'h1234, 8'h00);
    step(1'b1, 1'b0, 16'h0006, 16'h0, 8'h00);
    idle(2);

    // Randomized traffic
    repeat (600) begin
      case ($urandom_range(0, 4))
        0:       ra = 16'($urandom_range(0, 7));
        1:       ra = 16'(16 + $urandom_range(0, 31));
        2:       ra = 16'h0100;
        3:       ra = 16'($urandom);
        default: ra = 16'($urandom_range(0, 48));
      endcase
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, 16'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end
    idle(5);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
